// File: rtl/regfile_pkg.sv
// Shared constants, write-back entry type and one-hot decode for the 32x32 register array.
// Used by wb_fifo and regfile_wb_queue (optional forwarding: REGFILE_WB_BYPASS_EN).
package regfile_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam int REG_N  = 32;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

    function automatic logic [REG_N-1:0] onehot_dec(input logic [REG_AW-1:0] addr);
        logic [REG_N-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry circular buffer of pending register writes, with an age-ordered view
// (index 0 = head) for hazard compares. Data view only exists with REGFILE_WB_BYPASS_EN.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [AW-1:0]       push_addr,
    input  logic [DW-1:0]       push_data,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output logic [AW-1:0]       head_addr,
    output logic [DW-1:0]       head_data,
    output logic [DEPTH*AW-1:0] view_addr,
`ifdef REGFILE_WB_BYPASS_EN
    output logic [DEPTH*DW-1:0] view_data,
`endif
    output logic [DEPTH-1:0]    view_vld
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Storage carries no reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_addr[wr_ptr] <= push_addr;
            mem_data[wr_ptr] <= push_data;
        end
    end

    assign head_addr = mem_addr[rd_ptr];
    assign head_data = mem_data[rd_ptr];

    always_comb begin
        view_addr = '0;
        view_vld  = '0;
`ifdef REGFILE_WB_BYPASS_EN
        view_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            view_addr[k*AW +: AW] = mem_addr[rd_ptr + PW'(k)];
`ifdef REGFILE_WB_BYPASS_EN
            view_data[k*DW +: DW] = mem_data[rd_ptr + PW'(k)];
`endif
            view_vld[k] = (CW'(k) < count);
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the register array D/En ports, with rs/rt pending-write hazard flags.
// REGFILE_WB_BYPASS_EN adds youngest-pending-data forwarding on rs_fwd/rt_fwd.
module regfile_wb_queue
    import regfile_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic             Clk,
    input  logic             Clrn,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [AW-1:0]    wb_addr,
    input  logic [DW-1:0]    wb_data,
    output logic [DW-1:0]    D,
    output logic [2**AW-1:0] En,
    input  logic [AW-1:0]    rs_addr,
    input  logic [AW-1:0]    rt_addr,
    output logic             rs_hit,
    output logic             rt_hit,
    output logic [DW-1:0]    rs_fwd,
    output logic [DW-1:0]    rt_fwd
);

    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic [AW-1:0]       head_addr;
    logic [DW-1:0]       head_data;
    logic [DEPTH*AW-1:0] view_addr;
    logic [DEPTH-1:0]    view_vld;
    logic                slot_vld;
    logic [AW-1:0]       slot_addr;
`ifdef REGFILE_WB_BYPASS_EN
    logic [DEPTH*DW-1:0] view_data;
`endif

    // r0 is hardwired to zero: the handshake completes but nothing is queued.
    assign wb_ready = !fifo_full;
    assign push     = wb_valid && wb_ready && (wb_addr != '0);
    assign pop      = !fifo_empty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk       (Clk),
        .rst_n     (Clrn),
        .push      (push),
        .push_addr (wb_addr),
        .push_data (wb_data),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_addr (head_addr),
        .head_data (head_data),
        .view_addr (view_addr),
`ifdef REGFILE_WB_BYPASS_EN
        .view_data (view_data),
`endif
        .view_vld  (view_vld)
    );

    // Output slot: one write presented to the array per cycle; D holds when idle.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            slot_vld  <= 1'b0;
            slot_addr <= '0;
            D         <= '0;
            En        <= '0;
        end else if (pop) begin
            slot_vld  <= 1'b1;
            slot_addr <= head_addr;
            D         <= head_data;
            En        <= onehot_dec(head_addr);
        end else begin
            slot_vld  <= 1'b0;
            En        <= '0;
        end
    end

    always_comb begin
        rs_hit = slot_vld && (slot_addr == rs_addr);
        rt_hit = slot_vld && (slot_addr == rt_addr);
        for (int k = 0; k < DEPTH; k++) begin
            if (view_vld[k] && (view_addr[k*AW +: AW] == rs_addr)) rs_hit = 1'b1;
            if (view_vld[k] && (view_addr[k*AW +: AW] == rt_addr)) rt_hit = 1'b1;
        end
        if (rs_addr == '0) rs_hit = 1'b0;
        if (rt_addr == '0) rt_hit = 1'b0;
    end

`ifdef REGFILE_WB_BYPASS_EN
    // Later matches override earlier ones: slot first, then FIFO head to tail.
    always_comb begin
        rs_fwd = '0;
        rt_fwd = '0;
        if (rs_addr != '0) begin
            if (slot_vld && (slot_addr == rs_addr)) rs_fwd = D;
            for (int k = 0; k < DEPTH; k++)
                if (view_vld[k] && (view_addr[k*AW +: AW] == rs_addr))
                    rs_fwd = view_data[k*DW +: DW];
        end
        if (rt_addr != '0) begin
            if (slot_vld && (slot_addr == rt_addr)) rt_fwd = D;
            for (int k = 0; k < DEPTH; k++)
                if (view_vld[k] && (view_addr[k*AW +: AW] == rt_addr))
                    rt_fwd = view_data[k*DW +: DW];
        end
    end
`else
    assign rs_fwd = '0;
    assign rt_fwd = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_wb_queue;
    import regfile_pkg::*;

    localparam int DEPTH = 2;

    logic        Clk;
    logic        Clrn;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [31:0] D;
    logic [31:0] En;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_hit;
    logic        rt_hit;
    logic [31:0] rs_fwd;
    logic [31:0] rt_fwd;

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .Clrn     (Clrn),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .D        (D),
        .En       (En),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_hit   (rs_hit),
        .rt_hit   (rt_hit),
        .rs_fwd   (rs_fwd),
        .rt_fwd   (rt_fwd)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: pending writes in acceptance order, plus the write on the array port.
    wb_entry_t   q[$];
    logic        m_vld;
    wb_entry_t   m_slot;
    logic [31:0] m_D;
    int          n_total;
    int          n_pass;
    int          n_fail;

    function automatic logic m_hit(input logic [4:0] a);
        if (a == 5'd0) return 1'b0;
        if (m_vld && m_slot.addr == a) return 1'b1;
        foreach (q[i]) if (q[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_fwd(input logic [4:0] a);
        logic [31:0] r;
        r = 32'd0;
`ifdef REGFILE_WB_BYPASS_EN
        if (a != 5'd0) begin
            if (m_vld && m_slot.addr == a) r = m_slot.data;
            foreach (q[i]) if (q[i].addr == a) r = q[i].data;
        end
`endif
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".En"},     En, m_vld ? (32'd1 << m_slot.addr) : 32'd0);
        chk({tag, ".D"},      D, m_D);
        chk({tag, ".ready"},  32'(wb_ready), 32'(q.size() < DEPTH));
        chk({tag, ".rs_hit"}, 32'(rs_hit), 32'(m_hit(rs_addr)));
        chk({tag, ".rt_hit"}, 32'(rt_hit), 32'(m_hit(rt_addr)));
        chk({tag, ".rs_fwd"}, rs_fwd, m_fwd(rs_addr));
        chk({tag, ".rt_fwd"}, rt_fwd, m_fwd(rt_addr));
    endtask

    task automatic model_reset();
        q.delete();
        m_vld  = 1'b0;
        m_slot = '0;
        m_D    = 32'd0;
    endtask

    // Drive one cycle of inputs (called #1 after an edge), advance the model at the edge, check #1 later.
    task automatic cycle(input logic v, input logic [4:0] a, input logic [31:0] d,
                         input logic [4:0] qa, input logic [4:0] qb, input string tag);
        logic acc;
        wb_valid = v;
        wb_addr  = a;
        wb_data  = d;
        rs_addr  = qa;
        rt_addr  = qb;
        acc      = v && (q.size() < DEPTH);
        @(posedge Clk);
        if (q.size() != 0) begin
            m_slot = q.pop_front();
            m_vld  = 1'b1;
            m_D    = m_slot.data;
        end else begin
            m_vld = 1'b0;
        end
        if (acc && a != 5'd0) q.push_back('{addr: a, data: d});
        #1;
        check_all(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ra;
        n_total  = 0;
        n_pass   = 0;
        n_fail   = 0;
        Clrn     = 1'b0;
        wb_valid = 1'b0;
        wb_addr  = 5'd0;
        wb_data  = 32'd0;
        rs_addr  = 5'd5;
        rt_addr  = 5'd9;
        model_reset();

        #12;
        check_all("reset");
        @(posedge Clk);
        #1;
        check_all("reset_edge");
        Clrn = 1'b1;

        // Single write r5
        cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6, "w5_acc");
        cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd6, "w5_slot");
        chk("w5.En_const", En, 32'h00000020);
        chk("w5.D_const", D, 32'hDEADBEEF);
        cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd6, "w5_done");
        chk("w5.En_clear", En, 32'h0);

        // r0 write is swallowed
        cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, "r0_acc");
        cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "r0_idle");
        chk("r0.En_const", En, 32'h0);
        chk("r0.rs_hit_const", 32'(rs_hit), 32'd0);

        // Back-to-back r1, r2, r3
        cycle(1'b1, 5'd1, 32'h11, 5'd2, 5'd3, "fill1");
        cycle(1'b1, 5'd2, 32'h22, 5'd2, 5'd3, "fill2");
        chk("fill.En_r1", En, 32'h2);
        cycle(1'b1, 5'd3, 32'h33, 5'd2, 5'd3, "fill3");
        chk("fill.En_r2", En, 32'h4);
        cycle(1'b0, 5'd0, 32'd0, 5'd2, 5'd3, "fill4");
        chk("fill.En_r3", En, 32'h8);
        cycle(1'b0, 5'd0, 32'd0, 5'd2, 5'd3, "fill5");

        // Two pending writes to r7
        cycle(1'b1, 5'd7, 32'hA, 5'd7, 5'd8, "haz1");
        cycle(1'b1, 5'd7, 32'hB, 5'd7, 5'd8, "haz2");
        chk("haz.rs_hit_const", 32'(rs_hit), 32'd1);
        chk("haz.rt_hit_const", 32'(rt_hit), 32'd0);
`ifdef REGFILE_WB_BYPASS_EN
        chk("haz.rs_fwd_const", rs_fwd, 32'hB);
`else
        chk("haz.rs_fwd_const", rs_fwd, 32'h0);
`endif
        cycle(1'b0, 5'd0, 32'd0, 5'd7, 5'd8, "haz3");
        chk("haz.D_last", D, 32'hB);
        cycle(1'b0, 5'd0, 32'd0, 5'd7, 5'd8, "haz4");
        chk("haz.rs_hit_clear", 32'(rs_hit), 32'd0);

        // Reset pulse while a write is on the array port and another is queued
        cycle(1'b1, 5'd9, 32'h99, 5'd10, 5'd9, "mid1");
        cycle(1'b1, 5'd10, 32'hAA, 5'd10, 5'd9, "mid2");
        wb_valid = 1'b0;
        #3;
        Clrn = 1'b0;
        #1;
        model_reset();
        check_all("mid_rst_async");
        @(posedge Clk);
        #1;
        check_all("mid_rst_hold");
        Clrn = 1'b1;
        cycle(1'b0, 5'd0, 32'd0, 5'd10, 5'd9, "mid_after1");
        cycle(1'b0, 5'd0, 32'd0, 5'd10, 5'd9, "mid_after2");
        chk("mid.En_none", En, 32'h0);

        // Random traffic with address collisions encouraged
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 3) != 0), ra, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), "rand");
        end
        cycle(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, "drain1");
        cycle(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, "drain2");
        cycle(1'b0, 5'd0, 32'd0, 5'd1, 5'd2, "drain3");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
